uart_packet_tx: RTL and testbench
=================================

Name: uart_packet_tx

Overview:
- Serial transmitter for the 8-byte RS232 packet protocol used by the board link.
- Sends read responses: after a read request completes and RAM data is available, it frames the 7-bit address and 32-bit RAM word into one packet and shifts it out on the TX line.
- Wire format is the same as the inbound receiver: 8N1, LSB first, 0x02 start byte, 0x03 end byte.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud).
- GAP_BITS, 1, idle (mark) bit-times inserted between consecutive bytes of a packet; 0 allowed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tx_start  in  1  one-cycle request to send a packet
- tx_addr  in  7  RAM address echoed in the packet
- tx_data  in  32  RAM read word to send
- tx  out  1  serial line, idle high
- busy  out  1  high while a packet is in flight
- done  out  1  one-cycle pulse when the last stop bit completes
- byte_idx  out  3  index of the byte currently on the line (0..7)

Behaviour:
- Reset: asynchronous, active-high. Outputs: tx=1, busy=0, done=0, byte_idx=0. Internal: state=IDLE, all counters=0.
- Reset mid-packet: tx returns high immediately (asynchronous). No done pulse. The partial packet is abandoned.
- All outputs are registered.
- Packet byte order, k = 0..7:
  - byte0 = 8'h02
  - byte1 = {1'b0, addr}; bit7 = 0 marks a read response
  - byte2 = data[7:0]
  - byte3 = data[15:8]
  - byte4 = data[23:16]
  - byte5 = data[31:24]
  - byte6 = 8'h00 (reserved)
  - byte7 = 8'h03
  - Bit b of byte k corresponds to packet bit 8k+b, matching the receiver's 64-bit layout.
- Acceptance: tx_start is sampled on the rising edge of clk when busy=0, including the cycle in which done is high.
  - tx_addr and tx_data are captured on that same edge into a 64-bit shift image.
  - tx_start is ignored while busy=1; no queuing.
- Latency: the start bit (tx=0) and busy=1 appear on the edge after acceptance.
- Bit timing: each start, data and stop bit is held for exactly CLKS_PER_BIT cycles. A baud counter counts 0..CLKS_PER_BIT-1 and wraps.
- State machine (states live in the shared package):
  - IDLE: tx=1. On accept → START.
  - START: tx=0 for one bit-time → DATA.
  - DATA: 8 bit-times, LSB first. The bit counter wraps 7→0 → STOP.
  - STOP: tx=1 for one bit-time.
    - If byte_idx==7 → IDLE, pulse done and clear busy on that transition edge.
    - Else if GAP_BITS>0 → GAP.
    - Else → START, with byte_idx incremented.
  - GAP: tx=1 for GAP_BITS bit-times → START, with byte_idx incremented on entering START.
- busy duration: exactly (80 + 7*GAP_BITS)*CLKS_PER_BIT cycles.
- byte_idx returns to 0 in IDLE.
- Width rules:
  - Baud counter: clog2(CLKS_PER_BIT) bits.
  - Gap counter: clog2(GAP_BITS+1) bits.
  - No arithmetic overflow is permitted at the maximum parameter values.

Decomposition:
- Shared package uart_pkg holds:
  - STX=8'h02, ETX=8'h03, FRAME_BYTES=8, RESP_FLAG=1'b0
  - the tx state enum (IDLE, START, DATA, STOP, GAP)
  - the receiver uses the same constants
- One sub-module is natural: uart_tx_byte.
  - Handles the single-byte 8N1 serializer plus baud counter.
  - Interface: load/byte in, ready/tx out.
  - uart_packet_tx sequences the bytes and the gap around it.

Test Plan (CLKS_PER_BIT=16, GAP_BITS=1 unless noted):
- Basic packet: tx_start with addr=7'h05, data=32'hDEADBEEF → decoded bytes 02,05,EF,BE,AD,DE,00,03. busy high exactly 1392 cycles. One done pulse.
- Bit timing: same packet → tx=0 starts 1 cycle after accept; every bit is 16 cycles; 16-cycle idle gaps between bytes; tx=1 after the final stop bit.
- Busy rejection: second tx_start with addr=7'h7F mid-packet → ignored. Output is still the first packet, and no second packet follows.
- Back-to-back: tx_start asserted in the done cycle with data=32'h00000001, addr=0 → second packet 02,00,01,00,00,00,00,03 starts the next edge, with no extra idle.
- Reset mid-packet: assert rst during byte3 → tx=1 within the same cycle, busy=0, no done. A fresh packet after reset is correct.
- GAP_BITS=0: packet with data=32'h12345678 → bytes 02,..,78,56,34,12,00,03 with no gaps; busy=1280 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Framing constants and state encodings shared by the board-link UART transmitter and receiver.
package uart_pkg;

    localparam logic [7:0] STX         = 8'h02;
    localparam logic [7:0] ETX         = 8'h03;
    localparam logic [7:0] RSVD_BYTE   = 8'h00;
    localparam int         FRAME_BYTES = 8;
    localparam logic       RESP_FLAG   = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        PKT_IDLE,
        PKT_LOAD,
        PKT_SEND,
        PKT_GAP
    } pkt_state_t;

    // Byte k of the frame occupies bits [8k+7:8k].
    function automatic logic [63:0] build_frame(input logic [6:0] addr, input logic [31:0] data);
        return {ETX, RSVD_BYTE, data, RESP_FLAG, addr, STX};
    endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// Request/status bundle between the read-response source and the packet transmitter.
interface uart_packet_tx_if;

    logic        tx_start;
    logic [6:0]  tx_addr;
    logic [31:0] tx_data;
    logic        tx;
    logic        busy;
    logic        done;
    logic [2:0]  byte_idx;

    modport master (
        output tx_start, tx_addr, tx_data,
        input  tx, busy, done, byte_idx
    );

    modport slave (
        input  tx_start, tx_addr, tx_data,
        output tx, busy, done, byte_idx
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer with its own baud counter; a new byte may be loaded in the
// last cycle of the stop bit so consecutive bytes can run with no idle between them.
//
// state | meaning
// IDLE  | line held at mark, ready for a byte
// START | start bit (0) on the line
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1); ready_o high in its final cycle
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       tx_o
);
    import uart_pkg::*;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign ready_o  = (state_q == IDLE) || ((state_q == STOP) && baud_end);
    assign tx_o     = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (load_i) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    shreg_d = byte_i;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (load_i) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        bit_d   = '0;
                        shreg_d = byte_i;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_packet_tx.sv
// Read-response packet transmitter: frames {STX, addr, data, rsvd, ETX} and feeds it byte by
// byte to the serializer, inserting GAP_BITS mark bit-times between bytes.
//
// state    | meaning
// PKT_IDLE | waiting for tx_start; frame captured on accept
// PKT_LOAD | hand byte 0 to the serializer, raise busy
// PKT_SEND | a byte is on the line; decide next step when its stop bit ends
// PKT_GAP  | inter-byte mark gap, then load the next byte
module uart_packet_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 1
) (
    input  logic             clk,
    input  logic             rst,
    uart_packet_tx_if.slave  bus
);
    import uart_pkg::*;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W  = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_BITS - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(FRAME_BYTES - 1);

    pkt_state_t        state_q, state_d;
    logic [63:0]       shift_q, shift_d;
    logic [2:0]        idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BAUD_W-1:0] gbaud_q, gbaud_d;
    logic [GAP_W-1:0]  gbit_q, gbit_d;
    logic              byte_load;
    logic              byte_ready;
    logic              tx_w;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk     (clk),
        .rst     (rst),
        .load_i  (byte_load),
        .byte_i  (shift_q[7:0]),
        .ready_o (byte_ready),
        .tx_o    (tx_w)
    );

    assign bus.tx       = tx_w;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.byte_idx = idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PKT_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gbaud_q <= '0;
            gbit_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gbaud_q <= gbaud_d;
            gbit_q  <= gbit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        gbaud_d   = gbaud_q;
        gbit_d    = gbit_q;
        byte_load = 1'b0;
        case (state_q)
            PKT_IDLE: begin
                busy_d = 1'b0;
                idx_d  = '0;
                if (bus.tx_start) begin
                    shift_d = build_frame(bus.tx_addr, bus.tx_data);
                    state_d = PKT_LOAD;
                end
            end
            PKT_LOAD: begin
                byte_load = 1'b1;
                shift_d   = {8'h00, shift_q[63:8]};
                busy_d    = 1'b1;
                state_d   = PKT_SEND;
            end
            PKT_SEND: begin
                // byte_ready here means the current stop bit ends on this edge.
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = PKT_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else if (GAP_BITS > 0) begin
                        state_d = PKT_GAP;
                        gbaud_d = '0;
                        gbit_d  = '0;
                    end else begin
                        byte_load = 1'b1;
                        shift_d   = {8'h00, shift_q[63:8]};
                        idx_d     = idx_q + 3'd1;
                    end
                end
            end
            PKT_GAP: begin
                if (gbaud_q == BAUD_LAST) begin
                    gbaud_d = '0;
                    if (gbit_q == GAP_LAST) begin
                        byte_load = 1'b1;
                        shift_d   = {8'h00, shift_q[63:8]};
                        idx_d     = idx_q + 3'd1;
                        state_d   = PKT_SEND;
                    end else begin
                        gbit_d = gbit_q + 1'b1;
                    end
                end else begin
                    gbaud_d = gbaud_q + 1'b1;
                end
            end
            default: begin
                state_d = PKT_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: cycle-exact line/status waveform against a bit-time model.
module tb_uart_packet_tx;

    localparam int C = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_packet_tx_if bus1 ();
    uart_packet_tx_if bus0 ();

    uart_packet_tx #(.CLKS_PER_BIT(C), .GAP_BITS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    uart_packet_tx #(.CLKS_PER_BIT(C), .GAP_BITS(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_tx(input int which);
        return (which == 0) ? bus0.tx : bus1.tx;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? bus0.done : bus1.done;
    endfunction

    function automatic logic [2:0] get_idx(input int which);
        return (which == 0) ? bus0.byte_idx : bus1.byte_idx;
    endfunction

    task automatic drive_start(input int which, input logic v, input logic [6:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus0.tx_start = v;
            bus0.tx_addr  = a;
            bus0.tx_data  = d;
        end else begin
            bus1.tx_start = v;
            bus1.tx_addr  = a;
            bus1.tx_data  = d;
        end
    endtask

    // Call at a negedge with tx_start already raised; checks every cycle of the packet.
    task automatic expect_packet(input int which, input logic [63:0] frame, input int gap,
                                 input int inj_n, input bit chain, input logic [6:0] c_addr,
                                 input logic [31:0] c_data, input string tag);
        int total, seg, k, r;
        int e_tx, e_busy, e_done, e_idx, n_busy, n_done;
        logic x_tx, x_busy, x_done;
        logic [2:0] x_idx;
        total  = (80 + 7 * gap) * C;
        seg    = (10 + gap) * C;
        e_tx   = 0; e_busy = 0; e_done = 0; e_idx = 0; n_busy = 0; n_done = 0;
        @(negedge clk);
        drive_start(which, 1'b0, 7'h00, 32'h0);
        if (get_tx(which) !== 1'b1) e_tx++;
        if (get_busy(which) !== 1'b0) e_busy++;
        if (get_done(which) !== 1'b0) e_done++;
        for (int n = 0; n <= total; n++) begin
            @(negedge clk);
            if (n == inj_n) drive_start(which, 1'b1, 7'h7F, 32'hFFFF_FFFF);
            else if (n == inj_n + 1) drive_start(which, 1'b0, 7'h00, 32'h0);
            if (n < total) begin
                k      = n / seg;
                r      = (n % seg) / C;
                x_tx   = (r == 0) ? 1'b0 : (r <= 8) ? frame[8 * k + r - 1] : 1'b1;
                x_busy = 1'b1;
                x_done = 1'b0;
                x_idx  = 3'(k);
            end else begin
                x_tx   = 1'b1;
                x_busy = 1'b0;
                x_done = 1'b1;
                x_idx  = 3'd0;
            end
            if (get_tx(which) !== x_tx) e_tx++;
            if (get_busy(which) !== x_busy) e_busy++;
            if (get_done(which) !== x_done) e_done++;
            if (get_idx(which) !== x_idx) e_idx++;
            if (get_busy(which) === 1'b1) n_busy++;
            if (get_done(which) === 1'b1) n_done++;
        end
        if (chain) drive_start(which, 1'b1, c_addr, c_data);
        chk_val({tag, " tx errs"}, 64'(e_tx), 64'd0);
        chk_val({tag, " busy errs"}, 64'(e_busy), 64'd0);
        chk_val({tag, " done errs"}, 64'(e_done), 64'd0);
        chk_val({tag, " byte_idx errs"}, 64'(e_idx), 64'd0);
        chk_val({tag, " busy cycles"}, 64'(n_busy), 64'(total));
        chk_val({tag, " done pulses"}, 64'(n_done), 64'd1);
    endtask

    task automatic idle_check(input int which, input int cycles, input string tag);
        int errs;
        errs = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (get_tx(which) !== 1'b1 || get_busy(which) !== 1'b0 || get_done(which) !== 1'b0) errs++;
        end
        chk_val({tag, " idle errs"}, 64'(errs), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_start(0, 1'b0, 7'h00, 32'h0);
        drive_start(1, 1'b0, 7'h00, 32'h0);
        repeat (3) @(negedge clk);
        chk_val("reset tx", 64'(bus1.tx), 64'd1);
        chk_val("reset busy", 64'(bus1.busy), 64'd0);
        chk_val("reset done", 64'(bus1.done), 64'd0);
        chk_val("reset byte_idx", 64'(bus1.byte_idx), 64'd0);
        chk_val("reset tx gap0", 64'(bus0.tx), 64'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic packet with a rejected request in the middle of it.
        drive_start(1, 1'b1, 7'h05, 32'hDEAD_BEEF);
        expect_packet(1, 64'h0300_DEAD_BEEF_0502, 1, 300, 1'b0, 7'h00, 32'h0, "basic");
        idle_check(1, 3 * 11 * C, "no second packet");

        // Back-to-back: next request raised in the done cycle.
        drive_start(1, 1'b1, 7'h05, 32'hDEAD_BEEF);
        expect_packet(1, 64'h0300_DEAD_BEEF_0502, 1, -5, 1'b1, 7'h00, 32'h0000_0001, "b2b first");
        expect_packet(1, 64'h0300_0000_0001_0002, 1, -5, 1'b0, 7'h00, 32'h0, "b2b second");
        idle_check(1, 20, "after b2b");

        // Reset during byte 3.
        drive_start(1, 1'b1, 7'h05, 32'hDEAD_BEEF);
        @(negedge clk);
        drive_start(1, 1'b0, 7'h00, 32'h0);
        repeat (3 * 11 * C + 4 * C) @(negedge clk);
        chk_val("byte_idx before reset", 64'(bus1.byte_idx), 64'd3);
        rst = 1'b1;
        #1;
        chk_val("tx on async reset", 64'(bus1.tx), 64'd1);
        chk_val("busy on async reset", 64'(bus1.busy), 64'd0);
        chk_val("byte_idx on async reset", 64'(bus1.byte_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_check(1, 40, "after reset");
        drive_start(1, 1'b1, 7'h41, 32'hA5C3_0F96);
        expect_packet(1, 64'h0300_A5C3_0F96_4102, 1, -5, 1'b0, 7'h00, 32'h0, "post reset");

        // Zero inter-byte gap.
        drive_start(0, 1'b1, 7'h2A, 32'h1234_5678);
        expect_packet(0, 64'h0300_1234_5678_2A02, 0, -5, 1'b0, 7'h00, 32'h0, "gap0");
        idle_check(0, 40, "after gap0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
